// File: rtl/mul_serial_pkg.sv
// ============================================================================
//  Module   : mul_serial_pkg
//  Brief    : Shared types and default sizing for the serial shift-add multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_serial_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mul_idx_cnt.sv
// ============================================================================
//  Module   : mul_idx_cnt
//  Brief    : Multiplier bit-index counter with clear, enable and terminal count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_idx_cnt
    import mul_serial_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [DEPTH-1:0] idx,
    output logic             tc
);

    logic [DEPTH-1:0] idx_d;
    logic [DEPTH-1:0] idx_q;

    // Clear outranks enable so an abort or finish always parks the index at 0.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (en) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;
    assign tc  = (idx_q == {DEPTH{1'b1}});

endmodule

`default_nettype wire

// File: rtl/mul_serial_acc.sv
// ============================================================================
//  Module   : mul_serial_acc
//  Brief    : Bit-serial signed multiplier; scans i_data0 LSB-first and
//             accumulates shifted copies of i_data1 into a 2*WIDTH product.
//             Optional early termination: define MUL_SERIAL_EARLY_TERM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_serial_acc
    import mul_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   i_data0,
    input  logic signed [WIDTH-1:0]   i_data1,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DEPTH-1:0]          o_idx,
    output logic signed [2*WIDTH-1:0] o_data
);

    state_e                     state_d, state_q;
    logic [WIDTH-1:0]           data0_d, data0_q;
    logic signed [WIDTH-1:0]    data1_d, data1_q;
    logic signed [2*WIDTH-1:0]  acc_d, acc_q;
    logic                       in_ready_d, in_ready_q;
    logic                       out_valid_d, out_valid_q;

    logic [DEPTH-1:0]           w_idx;
    logic                       w_tc;
    logic                       w_cnt_en;
    logic                       w_cnt_clr;
    logic                       w_stop;
    logic signed [2*WIDTH-1:0]  w_mcand;
    logic signed [2*WIDTH-1:0]  w_term;
    logic signed [2*WIDTH-1:0]  w_acc_step;

    mul_idx_cnt #(
        .DEPTH (DEPTH)
    ) u_idx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .idx   (w_idx),
        .tc    (w_tc)
    );

    // The MSB of the multiplier carries negative weight, so its term is subtracted.
    assign w_mcand    = {{WIDTH{data1_q[WIDTH-1]}}, data1_q};
    assign w_term     = data0_q[w_idx] ? (w_mcand << w_idx) : '0;
    assign w_acc_step = w_tc ? (acc_q - w_term) : (acc_q + w_term);

`ifdef MUL_SERIAL_EARLY_TERM_EN
    logic [WIDTH-1:0] w_upper;
    assign w_upper = (data0_q >> w_idx) >> 1;
    assign w_stop  = w_tc || (w_upper == '0);
`else
    assign w_stop  = w_tc;
`endif

    assign w_cnt_en  = (state_q == RUN) && en;
    assign w_cnt_clr = clr || (state_q == IDLE) || (w_cnt_en && w_stop);

    always_comb begin
        state_d = state_q;
        data0_d = data0_q;
        data1_d = data1_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data0_d = i_data0;
                    data1_d = i_data1;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    acc_d = w_acc_step;
                    if (w_stop) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
        end
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data0_q     <= '0;
            data1_q     <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign o_data    = acc_q;
    assign o_idx     = w_idx;

endmodule

`default_nettype wire

// File: tb/tb_mul_serial_acc.sv
// ============================================================================
//  Module   : tb_mul_serial_acc
//  Brief    : Self-checking bench for mul_serial_acc (directed steps, scoreboard).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_serial_acc;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               clr;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  i_data0;
    logic signed [7:0]  i_data1;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         o_idx;
    logic signed [15:0] o_data;

    int n_vec  = 0;
    int n_fail = 0;
    int prod_q[$];
    int lat_q[$];

    mul_serial_acc #(
        .WIDTH (8),
        .DEPTH (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_data0   (i_data0),
        .i_data1   (i_data1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o_idx     (o_idx),
        .o_data    (o_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edges counted from (and including) the accepting edge until out_valid rises.
    function automatic int exp_latency(input logic [7:0] a);
`ifdef MUL_SERIAL_EARLY_TERM_EN
        int h = 0;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) h = i;
        end
        return h + 2;
`else
        return 9;
`endif
    endfunction

    task automatic do_op(input int a, input int b, input int stall_at,
                         input int stall_len, input int hold);
        int lat;
        int exp_p;
        int exp_l;
        logic [7:0] a8;
        a8 = 8'(a);
        @(negedge clk);
        i_data0  = 8'(a);
        i_data1  = 8'(b);
        in_valid = 1'b1;
        prod_q.push_back(a * b);
        lat_q.push_back(exp_latency(a8) + stall_len);
        check("in_ready_before_accept", {31'd0, in_ready}, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        check("in_ready_after_accept", {31'd0, in_ready}, 0);
        while (out_valid !== 1'b1 && lat < 40) begin
            en = !(stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len);
            @(negedge clk);
            lat++;
        end
        en = 1'b1;
        exp_p = prod_q.pop_front();
        exp_l = lat_q.pop_front();
        check("latency", lat, exp_l);
        check("product", o_data, exp_p);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_data", o_data, exp_p);
            check("hold_valid", {31'd0, out_valid}, 1);
            check("hold_in_ready", {31'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_in_ready", {31'd0, in_ready}, 1);
        check("idle_out_valid", {31'd0, out_valid}, 0);
    endtask

    initial begin
        int guard;
        int seen;
        rst_n     = 1'b0;
        en        = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        i_data0   = '0;
        i_data1   = '0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_idx", {29'd0, o_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3, 5, 0, 0, 0);
        do_op(-128, -128, 0, 0, 0);
        do_op(-1, 127, 0, 0, 0);
        do_op(127, -128, 0, 0, 0);
        do_op(6, 7, 2, 4, 0);
        do_op(3, 5, 0, 0, 5);
        do_op(1, 7, 0, 0, 0);
        do_op(-1, 3, 0, 0, 0);

        // Abort with clr once the index reaches 4.
        @(negedge clk);
        i_data0  = 8'sd100;
        i_data1  = 8'sd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (o_idx !== 3'd4 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("clr_reached_idx4", {29'd0, o_idx}, 4);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_in_ready", {31'd0, in_ready}, 1);
        check("clr_out_valid", {31'd0, out_valid}, 0);
        check("clr_o_data", o_data, 0);
        check("clr_o_idx", {29'd0, o_idx}, 0);

        // clr together with in_valid in IDLE must not accept.
        clr      = 1'b1;
        in_valid = 1'b1;
        i_data0  = 8'sd5;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_valid_in_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        check("clr_valid_still_idle", {31'd0, in_ready}, 1);
        do_op(2, 2, 0, 0, 0);

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        i_data0  = 8'sd50;
        i_data1  = 8'sd50;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 1);
        check("arst_out_valid", {31'd0, out_valid}, 0);
        check("arst_o_data", o_data, 0);
        check("arst_o_idx", {29'd0, o_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("arst_no_pulse", seen, 0);
        do_op(2, 2, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_serial_acc.md
MUL_SERIAL_ACC -- requirements
Module: mul_serial_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 3: bit-index width, equal to log2(WIDTH).
REQ-003 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1 bit: advance enable; low freezes the RUN state.
REQ-006 SHALL have port clr, input, 1 bit: synchronous abort to IDLE.
REQ-007 SHALL have port in_valid, input, 1 bit: operand pair valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts operands.
REQ-009 SHALL have port i_data0, input, signed WIDTH bits: multiplier, scanned bit-serially.
REQ-010 SHALL have port i_data1, input, signed WIDTH bits: multiplicand.
REQ-011 SHALL have port out_valid, output, 1 bit: product valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts product.
REQ-013 SHALL have port o_idx, output, DEPTH bits: current multiplier bit index (debug and observability).
REQ-014 SHALL have port o_data, output, signed 2*WIDTH bits: product.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be high exactly in IDLE; out_valid SHALL be high exactly in DONE.
REQ-017 On an IDLE edge with in_valid high: SHALL latch both operands, clear the accumulator, set idx=0 and go to RUN.
REQ-018 RUN, en high, per edge: acc += (data0[idx] ? sext(data1) << idx : 0), with the term subtracted instead of added when idx==WIDTH-1 (two's-complement sign weight); then idx++.
REQ-019 RUN, en low: acc, idx and state SHALL hold.
REQ-020 RUN edge with idx==WIDTH-1 and en high: SHALL apply the final term and go to DONE; idx SHALL return to 0.
REQ-021 Without early termination, latency SHALL be WIDTH+1 edges from the accepting edge to out_valid high.
REQ-022 DONE: o_data SHALL hold the full-precision signed product until the out_valid&out_ready edge, then go to IDLE.
REQ-023 No new operand SHALL be accepted in the DONE-to-IDLE transition cycle; there is no bypass.
REQ-024 Arithmetic SHALL be 2*WIDTH-bit wrap-free; the case -2^(WIDTH-1) * -2^(WIDTH-1) SHALL give +2^(2*WIDTH-2) exactly.
REQ-025 clr SHALL have priority over every transition: next state IDLE, acc=0, idx=0; an in-flight operation or held product is discarded.
REQ-026 If clr and in_valid are both high in IDLE, the operands SHALL NOT be accepted.
REQ-027 o_data SHALL equal acc in all states; o_idx SHALL equal idx.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, acc=0, idx=0, latched operands 0. Outputs SHALL be in_ready=1, out_valid=0, o_data=0, o_idx=0.
REQ-029 Reset during RUN or DONE SHALL abandon the operation with no output pulse.

Configuration
REQ-030 Macro MUL_SERIAL_EARLY_TERM_EN SHALL control early termination.
REQ-031 When the macro is defined: at a RUN edge with en high, if all multiplier bits above the current idx are zero (sign bit included), the block SHALL go to DONE after applying the current term.
REQ-032 When the macro is not defined: RUN SHALL always last exactly WIDTH enabled cycles.

Structure
REQ-033 A shared package mul_serial_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and the default WIDTH and DEPTH constants.
REQ-034 One sub-module, mul_idx_cnt, SHALL hold the DEPTH-bit index counter with clear, enable and terminal-count output.
REQ-035 The top level SHALL hold the FSM, the operand registers and the accumulator.

Verification
REQ-036 3 * 5, en held high, macro off -> out_valid high 9 edges after acceptance, o_data=15.
REQ-037 -128 * -128 -> o_data=16384; -1 * 127 -> o_data=-127; 127 * -128 -> o_data=-16256.
REQ-038 6 * 7 with en low for 4 cycles mid-RUN -> out_valid delayed by exactly 4 edges, o_data=42.
REQ-039 Product ready with out_ready low for 5 cycles -> o_data stable, out_valid high, in_ready low; after out_ready goes high, the FSM reaches IDLE on the next edge.
REQ-040 clr pulsed at idx=4, or rst_n pulsed mid-RUN -> IDLE with acc=0 and no out_valid; a following 2 * 2 gives 4.
REQ-041 Macro on, 1 * 7 -> out_valid 2 edges after acceptance, o_data=7; -1 * 3 -> full 9-edge latency, o_data=-3.
